// File: rtl/cntr_seq_pkg.sv
// Shared types and defaults for the counter command sequencer.
package cntr_seq_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_UP    = 2'd1,
    OP_DOWN  = 2'd2,
    OP_CLEAR = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CLR  = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/cntr_seq_step_cnt.sv
// Loadable down-counter holding the remaining RUN steps; saturates at zero.
module step_cnt
  import cntr_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign zero_o = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && !zero_o)
      cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/updn_cntr.sv
// Up/down counter driven by the sequencer: sync clear > load > count; term_cnt
// flags the value about to wrap in the current direction.
module updn_cntr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             cnt_load,
  input  logic             up_dn,
  input  logic             ena,
  input  logic             s_reset,
  output logic [WIDTH-1:0] cnt_out,
  output logic             term_cnt
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign cnt_out  = cnt_q;
  assign term_cnt = up_dn ? (cnt_q == '1) : (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (s_reset)
      cnt_d = '0;
    else if (cnt_load)
      cnt_d = cnt_in;
    else if (ena)
      cnt_d = up_dn ? cnt_q + ONE : cnt_q - ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cntr_seq.sv
// Command sequencer for updn_cntr: LOAD / UP N / DOWN N / CLEAR over valid-ready,
// with registered strobes and done/wrap/last-value status.
module cntr_seq
  import cntr_seq_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter bit STOP_ON_TC = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] cnt_in,
  output logic             cnt_load,
  output logic             up_dn,
  output logic             ena,
  output logic             s_reset,
  input  logic [WIDTH-1:0] cnt_out,
  input  logic             term_cnt,
  output logic             busy,
  output logic             done,
  output logic             wrapped,
  output logic [WIDTH-1:0] last_val
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q;
  logic             rdy_en_q;
  logic [WIDTH-1:0] cnt_in_q, last_val_q;
  logic             cnt_load_q, up_dn_q, ena_q, s_reset_q;
  logic             busy_q, done_q, wrapped_q;

  op_e  op;
  logic accept, run_op, step_load, step_dec, step_zero, stop_now;

  // rdy_en_q keeps cmd_ready low until the first clock after reset release.
  assign cmd_ready = rdy_en_q && (state_q == S_IDLE);
  assign op        = op_e'(cmd_op);
  assign accept    = cmd_valid && cmd_ready;
  assign run_op    = (op == OP_UP) || (op == OP_DOWN);
  assign step_load = accept && run_op && (cmd_data != '0);
  assign step_dec  = (state_q == S_RUN);
  assign stop_now  = step_zero || (STOP_ON_TC && term_cnt);

  // Loaded with N-1 so the zero flag marks the final RUN cycle.
  step_cnt #(.WIDTH(WIDTH)) u_step_cnt (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (step_load),
    .load_val_i (cmd_data - ONE),
    .dec_i      (step_dec),
    .zero_o     (step_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rdy_en_q   <= 1'b0;
      cnt_in_q   <= '0;
      cnt_load_q <= 1'b0;
      up_dn_q    <= 1'b1;
      ena_q      <= 1'b0;
      s_reset_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wrapped_q  <= 1'b0;
      last_val_q <= '0;
    end else begin
      rdy_en_q   <= 1'b1;
      cnt_load_q <= 1'b0;
      s_reset_q  <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            wrapped_q <= 1'b0;
            case (op)
              OP_LOAD: begin
                cnt_in_q   <= cmd_data;
                cnt_load_q <= 1'b1;
                ena_q      <= 1'b1;
                busy_q     <= 1'b1;
                state_q    <= S_LOAD;
              end
              OP_CLEAR: begin
                s_reset_q <= 1'b1;
                ena_q     <= 1'b1;
                busy_q    <= 1'b1;
                state_q   <= S_CLR;
              end
              default: begin
                up_dn_q <= (op == OP_UP);
                if (cmd_data == '0) begin
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
                end else begin
                  ena_q   <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
                end
              end
            endcase
          end
        end
        S_LOAD, S_CLR: begin
          ena_q   <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_RUN: begin
          if (term_cnt) wrapped_q <= 1'b1;
          if (stop_now) begin
            ena_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          last_val_q <= cnt_out;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cnt_in   = cnt_in_q;
  assign cnt_load = cnt_load_q;
  assign up_dn    = up_dn_q;
  assign ena      = ena_q;
  assign s_reset  = s_reset_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wrapped  = wrapped_q;
  assign last_val = last_val_q;

endmodule

// File: tb/tb_cntr_seq.sv
// Bench: two sequencers (STOP_ON_TC=0 and 1), each driving a real updn_cntr,
// checked every cycle against a per-command expected-output schedule.
module tb_cntr_seq;
  import cntr_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cmd_valid;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;

  wire  [1:0] cmd_ready, cnt_load, up_dn, ena, s_reset, busy, done, wrapped, term_cnt;
  wire  [7:0] cnt_in [2];
  wire  [7:0] last_val [2];
  wire  [7:0] cnt_out [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cntr_seq #(.WIDTH(8), .STOP_ON_TC(g == 1)) u_seq (
      .clk       (clk),
      .reset     (rst),
      .cmd_valid (cmd_valid[g]),
      .cmd_ready (cmd_ready[g]),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cnt_in    (cnt_in[g]),
      .cnt_load  (cnt_load[g]),
      .up_dn     (up_dn[g]),
      .ena       (ena[g]),
      .s_reset   (s_reset[g]),
      .cnt_out   (cnt_out[g]),
      .term_cnt  (term_cnt[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .wrapped   (wrapped[g]),
      .last_val  (last_val[g])
    );
    updn_cntr #(.WIDTH(8)) u_cnt (
      .clk      (clk),
      .reset_n  (!rst),
      .cnt_in   (cnt_in[g]),
      .cnt_load (cnt_load[g]),
      .up_dn    (up_dn[g]),
      .ena      (ena[g]),
      .s_reset  (s_reset[g]),
      .cnt_out  (cnt_out[g]),
      .term_cnt (term_cnt[g])
    );
  end

  typedef struct packed {
    logic       rdy, ld, sr, en, ud, bz, dn, wr;
    logic [7:0] ci, lv;
  } obs_t;

  // Expected outputs, one entry per cycle of the command in flight.
  obs_t       sched [2][0:299];
  int         head [2];
  int         tail [2];
  logic [7:0] m_ci [2];
  logic [7:0] m_lv [2];
  logic [7:0] m_val [2];
  logic       m_ud [2];
  logic       m_wr [2];
  logic       m_arm [2];

  int n_chk = 0;
  int n_fail = 0;
  int en_tot [2];
  bit fin = 1'b0;

  function automatic obs_t mk(int k, logic ld, logic sr, logic en, logic bz, logic dn);
    obs_t o;
    o.rdy = 1'b0; o.ld = ld; o.sr = sr; o.en = en; o.ud = m_ud[k];
    o.bz = bz; o.dn = dn; o.wr = m_wr[k]; o.ci = m_ci[k]; o.lv = m_lv[k];
    return o;
  endfunction

  function automatic void push(int k, logic ld, logic sr, logic en, logic bz, logic dn);
    sched[k][tail[k]] = mk(k, ld, sr, en, bz, dn);
    tail[k]++;
  endfunction

  function automatic void model_reset(int k);
    head[k] = 0; tail[k] = 0;
    m_ci[k] = 8'h00; m_lv[k] = 8'h00; m_val[k] = 8'h00;
    m_ud[k] = 1'b1; m_wr[k] = 1'b0; m_arm[k] = 1'b0;
  endfunction

  // Build the whole cycle-by-cycle outcome of one accepted command.
  function automatic void gen(int k, logic [1:0] op, logic [7:0] d);
    logic tc;
    head[k] = 0; tail[k] = 0;
    m_wr[k] = 1'b0;
    if (op == 2'd0) begin
      m_ci[k] = d;
      push(k, 1, 0, 1, 1, 0);
      m_val[k] = d;
    end else if (op == 2'd3) begin
      push(k, 0, 1, 1, 1, 0);
      m_val[k] = 8'h00;
    end else begin
      m_ud[k] = (op == 2'd1);
      for (int i = 0; i < int'(d); i++) begin
        push(k, 0, 0, 1, 1, 0);
        tc = m_ud[k] ? (m_val[k] == 8'hFF) : (m_val[k] == 8'h00);
        m_val[k] = m_ud[k] ? m_val[k] + 8'd1 : m_val[k] - 8'd1;
        if (tc) m_wr[k] = 1'b1;
        if (tc && k == 1) break;
      end
    end
    push(k, 0, 0, 0, 0, 1);
    m_lv[k] = m_val[k];
  endfunction

  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(posedge clk or posedge rst);
      for (int k = 0; k < 2; k++) begin
        if (rst) model_reset(k);
        else begin
          automatic bit acc = cmd_valid[k] && m_arm[k] && (head[k] == tail[k]);
          if (head[k] < tail[k]) head[k]++;
          m_arm[k] = 1'b1;
          if (acc) gen(k, cmd_op, cmd_data);
        end
      end
    end
  end

  initial begin
    en_tot[0] = 0; en_tot[1] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        obs_t exp_o, got_o;
        if (head[k] < tail[k]) exp_o = sched[k][head[k]];
        else begin
          exp_o = mk(k, 0, 0, 0, 0, 0);
          exp_o.rdy = m_arm[k];
        end
        got_o = {cmd_ready[k], cnt_load[k], s_reset[k], ena[k], up_dn[k], busy[k],
                 done[k], wrapped[k], cnt_in[k], last_val[k]};
        if (ena[k]) en_tot[k]++;
        if (!fin) begin
          n_chk++;
          if (got_o !== exp_o) begin
            n_fail++;
            $display("FAIL outputs dut%0d t=%0t got %h expected %h (rdy,ld,sr,en,ud,bz,dn,wr,cnt_in,last_val)",
                     k, $time, got_o, exp_o);
          end
        end
      end
    end
  end

  task automatic chk(string name, logic [7:0] got, logic [7:0] exp_v);
    n_chk++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp_v);
    end
  endtask

  // Present a command; returns 1 ns after its accept edge.
  task automatic send(int k, logic [1:0] op, logic [7:0] d, bit hold);
    bit ok = 1'b0;
    cmd_op = op; cmd_data = d; cmd_valid[k] = 1'b1;
    for (int i = 0; i < 700; i++) begin
      automatic logic r = cmd_ready[k];
      @(posedge clk);
      if (r) begin ok = 1'b1; break; end
      #1;
    end
    if (!ok) begin
      n_fail++;
      $display("FAIL accept_timeout dut%0d: got no accept expected accept", k);
    end
    #1;
    cmd_op = 2'($urandom); cmd_data = 8'($urandom);
    if (!hold) cmd_valid[k] = 1'b0;
  endtask

  task automatic wait_idle(int k);
    bit ok = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (cmd_ready[k]) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_fail++;
      $display("FAIL idle_timeout dut%0d: got busy expected idle", k);
    end
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end expected end of test");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1);
  end

  initial begin
    int e0;
    logic [1:0] op;
    logic [7:0] d;
    rst = 1'b0; cmd_valid = 2'b00; cmd_op = 2'd0; cmd_data = 8'h00;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ready", {7'd0, cmd_ready[0]}, 8'h00);
    chk("reset_up_dn", {7'd0, up_dn[0]}, 8'h01);
    chk("reset_last_val", last_val[0], 8'h00);
    #2 rst = 1'b0;
    #1 chk("ready_before_first_clk", {7'd0, cmd_ready[0]}, 8'h00);
    @(negedge clk);
    chk("ready_after_first_clk", {7'd0, cmd_ready[0]}, 8'h01);

    // LOAD 0x02: one load strobe, done next, last_val 0x02
    send(0, OP_LOAD, 8'h02, 0);
    @(negedge clk);
    chk("load_strobe", {7'd0, cnt_load[0]}, 8'h01);
    chk("load_cnt_in", cnt_in[0], 8'h02);
    @(negedge clk);
    chk("load_done", {7'd0, done[0]}, 8'h01);
    wait_idle(0);
    chk("load_last_val", last_val[0], 8'h02);

    // LOAD 0x10 then UP 5 with valid held: 1 + 5 enable cycles
    e0 = en_tot[0];
    send(0, OP_LOAD, 8'h10, 1);
    send(0, OP_UP, 8'd5, 0);
    wait_idle(0);
    chk("up5_ena_cycles", 8'(en_tot[0] - e0), 8'd6);
    chk("up5_last_val", last_val[0], 8'h15);
    chk("up5_wrapped", {7'd0, wrapped[0]}, 8'h00);

    // LOAD 0x02, DOWN 4 without early stop: 02,01,00,FF -> FE
    e0 = en_tot[0];
    send(0, OP_LOAD, 8'h02, 1);
    send(0, OP_DOWN, 8'd4, 0);
    wait_idle(0);
    chk("down4_ena_cycles", 8'(en_tot[0] - e0), 8'd5);
    chk("down4_last_val", last_val[0], 8'hFE);
    chk("down4_wrapped", {7'd0, wrapped[0]}, 8'h01);

    // Same with early stop: term_cnt at 00, that step still lands -> FF
    e0 = en_tot[1];
    send(1, OP_LOAD, 8'h02, 1);
    send(1, OP_DOWN, 8'd4, 0);
    wait_idle(1);
    chk("stop_ena_cycles", 8'(en_tot[1] - e0), 8'd4);
    chk("stop_last_val", last_val[1], 8'hFF);
    chk("stop_wrapped", {7'd0, wrapped[1]}, 8'h01);

    // UP 0: done straight after accept, no enable
    send(0, OP_UP, 8'd0, 0);
    @(negedge clk);
    chk("up0_done", {7'd0, done[0]}, 8'h01);
    chk("up0_ena", {7'd0, ena[0]}, 8'h00);
    wait_idle(0);

    // CLEAR
    send(0, OP_CLEAR, 8'hAB, 0);
    @(negedge clk);
    chk("clear_s_reset", {7'd0, s_reset[0]}, 8'h01);
    wait_idle(0);
    chk("clear_last_val", last_val[0], 8'h00);

    // Random commands, valid sometimes held across back-to-back commands
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 30; i++) begin
        op = 2'($urandom);
        d = ($urandom_range(0, 7) == 0 || op == 2'd0) ? 8'($urandom) : 8'($urandom_range(0, 12));
        send(k, op, d, (i < 29) && ($urandom_range(0, 1) == 1));
        if (!cmd_valid[k]) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle(k);
    end

    // Async reset in the 3rd enable cycle of UP 10
    send(0, OP_UP, 8'd10, 0);
    @(posedge clk);
    @(posedge clk);
    #2 chk("midrun_ena_before", {7'd0, ena[0]}, 8'h01);
    #1 rst = 1'b1;
    #1;
    chk("midrun_ena", {7'd0, ena[0]}, 8'h00);
    chk("midrun_busy", {7'd0, busy[0]}, 8'h00);
    chk("midrun_done", {7'd0, done[0]}, 8'h00);
    chk("midrun_ready", {7'd0, cmd_ready[0]}, 8'h00);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("rel_ready_before_clk", {7'd0, cmd_ready[0]}, 8'h00);
    @(negedge clk);
    chk("rel_ready_after_clk", {7'd0, cmd_ready[0]}, 8'h01);
    chk("rel_no_done", {7'd0, done[0]}, 8'h00);

    send(0, OP_LOAD, 8'h5A, 0);
    wait_idle(0);
    chk("post_reset_load", last_val[0], 8'h5A);

    @(negedge clk);
    fin = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
